// File: rtl/alu_seq_multiplier_if.sv
// Bundle for the sequential multiplier: start/operand handshake, product/status
// outputs, and the initiator side of the shared datapath ALU.
interface alu_seq_multiplier_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product;
   logic             product_zero;
   logic [WIDTH-1:0] alu_A;
   logic [WIDTH-1:0] alu_B;
   logic [2:0]       alu_control;
   logic [WIDTH-1:0] alu_out;
   logic             alu_overflow;
   logic             alu_zero;
   logic             alu_negative;

   // Multiplier side: answers the start request and drives the ALU operands.
   modport slave (
      input  start, a, b, alu_out, alu_overflow, alu_zero, alu_negative,
      output busy, done, product, product_zero, alu_A, alu_B, alu_control
   );

   // Environment side: requester plus the combinational ALU.
   modport master (
      output start, a, b, alu_out, alu_overflow, alu_zero, alu_negative,
      input  busy, done, product, product_zero, alu_A, alu_B, alu_control
   );
endinterface

// File: rtl/alu_seq_multiplier.sv
// Shift-add multiplier that borrows the datapath ALU for one ADD per step and
// returns the low WIDTH bits of a*b with a start/done handshake.
//
// state  | meaning
// IDLE   | waiting for start; product holds last result
// RUN    | one shift-add step per cycle through the external ALU
// DONE   | single-cycle done pulse, product valid
module alu_seq_multiplier #(
   parameter int         WIDTH      = 32,
   parameter logic [2:0] ALU_ADD    = 3'b010,
   parameter bit         EARLY_EXIT = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset,
   alu_seq_multiplier_if.slave  bus
);
   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [CW-1:0]    count_q;
   logic             busy_q;
   logic             done_q;
   logic [2:0]       ctrl_q;
   logic [WIDTH-1:0] product_q;
   logic             pzero_q;

   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] mcand_d;
   logic [WIDTH-1:0] mplier_d;
   logic             last_step;

   always_comb begin
      acc_d     = mplier_q[0] ? bus.alu_out : acc_q;
      mcand_d   = mcand_q << 1;
      mplier_d  = mplier_q >> 1;
      last_step = (count_q == LAST) || (EARLY_EXIT && (mplier_d == '0));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ctrl_q    <= 3'b000;
         product_q <= '0;
         pzero_q   <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  mcand_q  <= bus.a;
                  mplier_q <= bus.b;
                  acc_q    <= '0;
                  count_q  <= '0;
                  busy_q   <= 1'b1;
                  ctrl_q   <= ALU_ADD;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               count_q  <= count_q + CW'(1);
               if (last_step) begin
                  // Publish on the edge into DONE so product is valid with done.
                  product_q <= acc_d;
                  pzero_q   <= (acc_d == '0);
                  done_q    <= 1'b1;
                  ctrl_q    <= 3'b000;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               ctrl_q  <= 3'b000;
            end
         endcase
      end
   end

   // Carry-out and flags are irrelevant to a modulo-2^WIDTH product.
   logic unused_flags;
   assign unused_flags = ^{bus.alu_overflow, bus.alu_zero, bus.alu_negative};

   assign bus.alu_A        = acc_q;
   assign bus.alu_B        = mcand_q;
   assign bus.alu_control  = ctrl_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.product      = product_q;
   assign bus.product_zero = pzero_q;
endmodule
